aes_block_ctrl: RTL and testbench

//  Upstream request front-end for the AES cipher core.
//  - Accepts {key, key length, direction, 128-bit block} requests on a valid/ready port.
//  - Launches each request into the core with a one-cycle CK strobe, then waits for CF.
//  - Captures state_o into an output FIFO drained by a valid/ready result port.
//  - Provides a CF timeout watchdog and block counters for the UVM environment.

---
 rtl/aes_block_ctrl_pkg.sv | 21 ++
 rtl/aes_block_ctrl_if.sv | 42 ++++
 rtl/aes_block_ctrl_rsp_fifo.sv | 54 +++++
 rtl/aes_block_ctrl.sv | 136 +++++++++++++
 tb/tb_aes_block_ctrl.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_block_ctrl_pkg.sv
// Shared types for the AES block request front-end: FSM states, key-length
// codes and the result FIFO entry layout.
package aes_ctrl_pkg;

    localparam int AES_KEY_W = 256;
    localparam int AES_BLK_W = 128;

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, ERR} aes_ctrl_state_e;

    typedef enum logic [1:0] {KL_128, KL_192, KL_256, KL_BAD} aes_kl_e;

    typedef struct packed {
        logic                 err;
        logic [AES_BLK_W-1:0] blk;
    } aes_rsp_t;

    function automatic logic kl_is_bad(input logic [1:0] kl);
        return aes_kl_e'(kl) == KL_BAD;
    endfunction

endpackage

// File: rtl/aes_block_ctrl_if.sv
// Request, result and core-side signal bundle of the AES block front-end.
// valid/ready: a transfer happens on a rising edge where both are 1; the
// source holds its payload stable while valid is 1 and ready is 0.
interface aes_block_ctrl_if #(
    parameter int KEY_W = 256,
    parameter int BLK_W = 128
);
    logic             req_valid;
    logic             req_ready;
    logic [KEY_W-1:0] req_key;
    logic [1:0]       req_kl;
    logic             req_enc_dec;
    logic [BLK_W-1:0] req_block;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [BLK_W-1:0] rsp_block;
    logic             rsp_err;

    logic             core_ck;
    logic [KEY_W-1:0] core_key;
    logic [1:0]       core_kl;
    logic             core_enc_dec;
    logic [BLK_W-1:0] core_state;
    logic [BLK_W-1:0] core_state_o;
    logic             core_cf;

    modport slave (
        input  req_valid, req_key, req_kl, req_enc_dec, req_block,
        input  rsp_ready, core_state_o, core_cf,
        output req_ready, rsp_valid, rsp_block, rsp_err,
        output core_ck, core_key, core_kl, core_enc_dec, core_state
    );

    modport master (
        output req_valid, req_key, req_kl, req_enc_dec, req_block,
        output rsp_ready, core_state_o, core_cf,
        input  req_ready, rsp_valid, rsp_block, rsp_err,
        input  core_ck, core_key, core_kl, core_enc_dec, core_state
    );

endinterface

// File: rtl/aes_block_ctrl_rsp_fifo.sv
// Small synchronous result FIFO; head is combinational and reads as zero
// while empty so the result port idles at 0.
module aes_rsp_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 129
) (
    input  logic                     CLK,
    input  logic                     CLR,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_en;
    logic          rd_en;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign rd_en = pop && !empty;
    // A pop frees the slot being written, so push into a full FIFO is legal then.
    assign wr_en = push && (!full || rd_en);
    assign head  = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/aes_block_ctrl.sv
// AES block request front-end: accepts one request at a time, strobes the
// cipher core, waits for CF under a watchdog and queues results.
module aes_block_ctrl
    import aes_ctrl_pkg::*;
#(
    parameter int KEY_W     = AES_KEY_W,
    parameter int BLK_W     = AES_BLK_W,
    parameter int OUT_DEPTH = 2,
    parameter int TIMEOUT   = 64,
    parameter int CNT_W     = 16
) (
    input  logic                        CLK,
    input  logic                        CLR,
    aes_block_ctrl_if.slave             bus,
    output logic                        timeout_err,
    output logic [CNT_W-1:0]            blk_cnt,
    output logic [$clog2(OUT_DEPTH):0]  rsp_count,
    output aes_ctrl_state_e             fsm_state
);
    localparam int WD_W = $clog2(TIMEOUT);

    aes_ctrl_state_e  state;
    aes_ctrl_state_e  next_state;
    logic             armed;
    logic             accept;
    logic             ready;
    logic             launch;
    logic             cf_done;
    logic             timeout_hit;
    logic             fifo_push;
    logic             fifo_full;
    logic             fifo_empty;
    aes_rsp_t         push_data;
    aes_rsp_t         head;
    logic [WD_W-1:0]  wd;
    logic [KEY_W-1:0] key_q;
    logic [1:0]       kl_q;
    logic             enc_dec_q;
    logic [BLK_W-1:0] block_q;

    assign accept = bus.req_valid && ready;

    always_ff @(posedge CLK) begin
        if (CLR) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = kl_is_bad(bus.req_kl) ? ERR : LAUNCH;
            LAUNCH:  next_state = WAIT;
            WAIT:    if (bus.core_cf || wd == '0) next_state = IDLE;
            ERR:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // armed keeps req_ready low for the first cycle after reset.
    always_comb begin
        ready          = 1'b0;
        launch         = 1'b0;
        cf_done        = 1'b0;
        timeout_hit    = 1'b0;
        fifo_push      = 1'b0;
        push_data.err  = 1'b0;
        push_data.blk  = bus.core_state_o;
        case (state)
            IDLE:   ready = armed && !fifo_full;
            LAUNCH: launch = 1'b1;
            WAIT: begin
                cf_done     = bus.core_cf;
                timeout_hit = !bus.core_cf && (wd == '0);
                fifo_push   = bus.core_cf;
            end
            ERR: begin
                fifo_push     = 1'b1;
                push_data.err = 1'b1;
                push_data.blk = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            armed       <= 1'b0;
            key_q       <= '0;
            kl_q        <= '0;
            enc_dec_q   <= 1'b0;
            block_q     <= '0;
            wd          <= '0;
            timeout_err <= 1'b0;
            blk_cnt     <= '0;
        end else begin
            armed <= 1'b1;
            if (accept) begin
                key_q     <= bus.req_key;
                kl_q      <= bus.req_kl;
                enc_dec_q <= bus.req_enc_dec;
                block_q   <= bus.req_block;
            end
            if (launch)                       wd <= WD_W'(TIMEOUT - 1);
            else if (state == WAIT && wd != '0) wd <= wd - 1'b1;
            if (timeout_hit) timeout_err <= 1'b1;
            if (cf_done)     blk_cnt     <= blk_cnt + 1'b1;
        end
    end

    aes_rsp_fifo #(
        .DEPTH (OUT_DEPTH),
        .W     ($bits(aes_rsp_t))
    ) u_rsp_fifo (
        .CLK       (CLK),
        .CLR       (CLR),
        .push      (fifo_push),
        .push_data (push_data),
        .pop       (bus.rsp_ready),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (rsp_count)
    );

    assign bus.req_ready    = ready;
    assign bus.rsp_valid    = !fifo_empty;
    assign bus.rsp_block    = head.blk;
    assign bus.rsp_err      = head.err;
    assign bus.core_ck      = launch;
    assign bus.core_key     = key_q;
    assign bus.core_kl      = kl_q;
    assign bus.core_enc_dec = enc_dec_q;
    assign bus.core_state   = block_q;
    assign fsm_state        = state;

endmodule

// File: tb/tb_aes_block_ctrl.sv
// Directed bench for aes_block_ctrl with a behavioural cipher-core stand-in
// that answers known FIPS-197 vectors and inverts any other block.
module tb_aes_block_ctrl;
    import aes_ctrl_pkg::*;

    localparam logic [255:0] KEY128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] BLK_A  = 128'h0123456789abcdef0123456789abcdef;
    localparam logic [127:0] BLK_B  = 128'h00000000000000000000000000000000;
    localparam logic [127:0] BLK_C  = 128'hffffffffffffffff0000000000000000;
    localparam logic [127:0] INV_A  = 128'hfedcba9876543210fedcba9876543210;
    localparam logic [127:0] INV_B  = 128'hffffffffffffffffffffffffffffffff;
    localparam logic [127:0] INV_C  = 128'h0000000000000000ffffffffffffffff;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    aes_block_ctrl_if bus ();
    logic            timeout_err;
    logic [15:0]     blk_cnt;
    logic [1:0]      rsp_count;
    aes_ctrl_state_e fsm_state;

    aes_block_ctrl dut (
        .CLK         (clk),
        .CLR         (clr),
        .bus         (bus),
        .timeout_err (timeout_err),
        .blk_cnt     (blk_cnt),
        .rsp_count   (rsp_count),
        .fsm_state   (fsm_state)
    );

    int checks   = 0;
    int failures = 0;

    int           core_lat  = 3;
    bit           cf_enable = 1'b1;
    int           ck_cnt    = 0;
    bit           busy;
    int           lat_left;
    logic [127:0] core_res;

    function automatic logic [127:0] core_fn(input logic [255:0] key, input logic [1:0] kl,
                                             input logic enc, input logic [127:0] blk);
        if (enc && kl == 2'b00 && key == KEY128 && blk == PT) return CT128;
        if (!enc && kl == 2'b10 && key == KEY256 && blk == CT256) return PT;
        return ~blk;
    endfunction

    // Core stand-in: runs on the falling edge so CF is stable at the DUT's rising edge.
    initial begin
        bus.core_cf      = 1'b0;
        bus.core_state_o = '0;
        busy             = 1'b0;
        lat_left         = 0;
        forever begin
            @(negedge clk);
            bus.core_cf = 1'b0;
            if (busy) begin
                if (lat_left == 0) begin
                    busy = 1'b0;
                    if (cf_enable) begin
                        bus.core_cf      = 1'b1;
                        bus.core_state_o = core_res;
                    end
                end else begin
                    lat_left--;
                end
            end
            if (bus.core_ck === 1'b1) begin
                ck_cnt++;
                busy     = 1'b1;
                lat_left = core_lat - 1;
                core_res = core_fn(bus.core_key, bus.core_kl, bus.core_enc_dec, bus.core_state);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input string tag, input logic [255:0] key, input logic [1:0] kl,
                        input logic enc, input logic [127:0] blk);
        bus.req_valid   = 1'b1;
        bus.req_key     = key;
        bus.req_kl      = kl;
        bus.req_enc_dec = enc;
        bus.req_block   = blk;
        for (int i = 0; i < 200; i++) begin
            if (bus.req_ready === 1'b1) break;
            tick(1);
        end
        check({tag, "_req_ready"}, 256'(bus.req_ready), 256'(1));
        tick(1);
        bus.req_valid = 1'b0;
    endtask

    task automatic recv(input string tag, input logic [127:0] exp_blk, input logic exp_err);
        for (int i = 0; i < 200; i++) begin
            if (bus.rsp_valid === 1'b1) break;
            tick(1);
        end
        check({tag, "_rsp_valid"}, 256'(bus.rsp_valid), 256'(1));
        check({tag, "_rsp_block"}, 256'(bus.rsp_block), 256'(exp_blk));
        check({tag, "_rsp_err"}, 256'(bus.rsp_err), 256'(exp_err));
        bus.rsp_ready = 1'b1;
        tick(1);
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench time limit reached");
    end

    initial begin
        clr             = 1'b1;
        bus.req_valid   = 1'b0;
        bus.req_key     = '0;
        bus.req_kl      = 2'b00;
        bus.req_enc_dec = 1'b0;
        bus.req_block   = '0;
        bus.rsp_ready   = 1'b0;
        tick(3);

        check("rst_req_ready", 256'(bus.req_ready), 256'(0));
        check("rst_rsp_valid", 256'(bus.rsp_valid), 256'(0));
        check("rst_rsp_block", 256'(bus.rsp_block), 256'(0));
        check("rst_core_ck", 256'(bus.core_ck), 256'(0));
        check("rst_core_key", bus.core_key, 256'(0));
        check("rst_blk_cnt", 256'(blk_cnt), 256'(0));
        check("rst_timeout_err", 256'(timeout_err), 256'(0));
        check("rst_state", 256'(fsm_state), 256'(IDLE));
        clr = 1'b0;
        tick(1);
        check("post_rst_req_ready", 256'(bus.req_ready), 256'(1));

        // 1: AES-128 encrypt
        send("t1", KEY128, 2'b00, 1'b1, PT);
        check("t1_core_ck_latency", 256'(bus.core_ck), 256'(1));
        check("t1_state_launch", 256'(fsm_state), 256'(LAUNCH));
        check("t1_core_key", bus.core_key, KEY128);
        check("t1_core_state", 256'(bus.core_state), 256'(PT));
        check("t1_req_ready_busy", 256'(bus.req_ready), 256'(0));
        tick(1);
        check("t1_core_ck_single", 256'(bus.core_ck), 256'(0));
        check("t1_state_wait", 256'(fsm_state), 256'(WAIT));
        for (int i = 0; i < 100; i++) begin
            if (bus.core_cf === 1'b1) break;
            tick(1);
        end
        check("t1_cf_to_rsp_valid", 256'(bus.rsp_valid), 256'(1));
        recv("t1", CT128, 1'b0);
        check("t1_ck_count", 256'(ck_cnt), 256'(1));
        check("t1_blk_cnt", 256'(blk_cnt), 256'(1));

        // 2: AES-256 decrypt
        send("t2", KEY256, 2'b10, 1'b0, CT256);
        recv("t2", PT, 1'b0);
        check("t2_blk_cnt", 256'(blk_cnt), 256'(2));

        // 3: result port stalled, FIFO fills, third request is held off
        send("t3a", KEY128, 2'b01, 1'b1, BLK_A);
        send("t3b", KEY128, 2'b01, 1'b1, BLK_B);
        bus.req_valid   = 1'b1;
        bus.req_kl      = 2'b00;
        bus.req_enc_dec = 1'b1;
        bus.req_block   = BLK_C;
        tick(20);
        check("t3_req_ready_full", 256'(bus.req_ready), 256'(0));
        check("t3_rsp_count", 256'(rsp_count), 256'(2));
        check("t3_blk_cnt", 256'(blk_cnt), 256'(4));
        check("t3_state_idle", 256'(fsm_state), 256'(IDLE));
        bus.req_valid = 1'b0;
        recv("t3a", INV_A, 1'b0);
        recv("t3b", INV_B, 1'b0);
        check("t3_drained", 256'(rsp_count), 256'(0));
        send("t3c", KEY128, 2'b00, 1'b1, BLK_C);
        recv("t3c", INV_C, 1'b0);
        check("t3_blk_cnt_end", 256'(blk_cnt), 256'(5));

        // 4: illegal key length
        send("t4", KEY128, 2'b11, 1'b1, PT);
        check("t4_state_err", 256'(fsm_state), 256'(ERR));
        check("t4_no_core_ck", 256'(bus.core_ck), 256'(0));
        recv("t4", 128'h0, 1'b1);
        check("t4_ck_count", 256'(ck_cnt), 256'(5));
        check("t4_blk_cnt", 256'(blk_cnt), 256'(5));

        // 5: CF withheld, watchdog fires TIMEOUT cycles after the strobe
        cf_enable = 1'b0;
        send("t5", KEY128, 2'b00, 1'b1, PT);
        tick(64);
        check("t5_no_timeout_yet", 256'(timeout_err), 256'(0));
        check("t5_still_wait", 256'(fsm_state), 256'(WAIT));
        tick(1);
        check("t5_timeout_err", 256'(timeout_err), 256'(1));
        check("t5_state_idle", 256'(fsm_state), 256'(IDLE));
        check("t5_no_push", 256'(bus.rsp_valid), 256'(0));
        check("t5_blk_cnt", 256'(blk_cnt), 256'(5));
        cf_enable = 1'b1;
        tick(2);
        send("t5n", KEY128, 2'b00, 1'b1, BLK_A);
        recv("t5n", INV_A, 1'b0);
        check("t5n_blk_cnt", 256'(blk_cnt), 256'(6));
        check("t5n_timeout_sticky", 256'(timeout_err), 256'(1));

        // 6: reset during WAIT, then the core's late CF
        core_lat = 20;
        send("t6", KEY128, 2'b00, 1'b1, BLK_B);
        tick(5);
        check("t6_state_wait", 256'(fsm_state), 256'(WAIT));
        clr = 1'b1;
        tick(1);
        check("t6_rst_req_ready", 256'(bus.req_ready), 256'(0));
        check("t6_rst_core_key", bus.core_key, 256'(0));
        check("t6_rst_core_state", 256'(bus.core_state), 256'(0));
        check("t6_rst_timeout_err", 256'(timeout_err), 256'(0));
        check("t6_rst_blk_cnt", 256'(blk_cnt), 256'(0));
        clr = 1'b0;
        tick(30);
        check("t6_late_cf_valid", 256'(bus.rsp_valid), 256'(0));
        check("t6_late_cf_count", 256'(rsp_count), 256'(0));
        check("t6_late_cf_blk_cnt", 256'(blk_cnt), 256'(0));
        check("t6_late_cf_timeout", 256'(timeout_err), 256'(0));
        check("t6_state_idle", 256'(fsm_state), 256'(IDLE));
        check("t6_req_ready", 256'(bus.req_ready), 256'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
